// File: rtl/mem_port_adapter_pkg.sv
// mem_port_adapter_pkg: shared state encoding and error read value for the memory port adapter
package mem_port_adapter_pkg;

    localparam logic [31:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_adapter_state_t;

endpackage

// File: rtl/mem_port_adapter_align.sv
// mem_align: shifts byte enables and store data to the address byte offset and flags misalignment
module mem_align (
    input  logic [1:0]  off,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [3:0]  be_sh,
    output logic [31:0] wdata_sh,
    output logic        misaligned
);

    logic [7:0] be8;

    // enables spilling into the upper nibble cross a word boundary
    always_comb begin
        be8        = {4'b0, be} << off;
        be_sh      = be8[3:0];
        misaligned = |be8[7:4];
        wdata_sh   = wdata << {off, 3'b000};
    end

endmodule

// File: rtl/mem_port_adapter.sv
// mem_port_adapter: turns level-held CPU memory requests into req/gnt + rvalid/wack transactions with timeout
module mem_port_adapter
    import mem_port_adapter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err,
    output logic        pmem_req,
    output logic        pmem_we,
    output logic [31:0] pmem_addr,
    output logic [3:0]  pmem_be,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_gnt,
    input  logic        pmem_rvalid,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_wack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_adapter_state_t state;
    logic [CW-1:0]      cnt;
    logic [3:0]         be_sh;
    logic [31:0]        wdata_sh;
    logic               misaligned;
    logic               timeout;
    logic               any_req;
    logic               illegal;

    mem_align u_align (
        .off        (mem_address[1:0]),
        .be         (mem_byte_enable),
        .wdata      (mem_wdata),
        .be_sh      (be_sh),
        .wdata_sh   (wdata_sh),
        .misaligned (misaligned)
    );

    // request classification and the last permitted REQ/WAIT cycle
    always_comb begin
        any_req = mem_read | mem_write;
        illegal = (mem_read & mem_write) | (any_req & misaligned);
        timeout = (TIMEOUT != 0) && (32'(cnt) == 32'(TIMEOUT - 1));
    end

    // transaction FSM with registered outputs; completion wins over a same-cycle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_resp   <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= '0;
            pmem_req   <= 1'b0;
            pmem_we    <= 1'b0;
            pmem_addr  <= '0;
            pmem_be    <= '0;
            pmem_wdata <= '0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (illegal) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        mem_err  <= 1'b1;
                        if (mem_read)
                            mem_rdata <= MEM_ERR_RDATA;
                    end else if (any_req) begin
                        state      <= REQ;
                        mem_err    <= 1'b0;
                        pmem_req   <= 1'b1;
                        pmem_we    <= mem_write;
                        pmem_addr  <= {mem_address[31:2], 2'b00};
                        pmem_be    <= mem_write ? be_sh : 4'hf;
                        pmem_wdata <= wdata_sh;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (pmem_gnt && !pmem_we && pmem_rvalid) begin
                        state     <= RESP;
                        mem_resp  <= 1'b1;
                        mem_rdata <= pmem_rdata;
                        pmem_req  <= 1'b0;
                    end else if (timeout) begin
                        state     <= RESP;
                        mem_resp  <= 1'b1;
                        mem_err   <= 1'b1;
                        mem_rdata <= MEM_ERR_RDATA;
                        pmem_req  <= 1'b0;
                    end else if (pmem_gnt) begin
                        state    <= WAIT;
                        pmem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (pmem_we ? pmem_wack : pmem_rvalid) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        if (!pmem_we)
                            mem_rdata <= pmem_rdata;
                    end else if (timeout) begin
                        state     <= RESP;
                        mem_resp  <= 1'b1;
                        mem_err   <= 1'b1;
                        mem_rdata <= MEM_ERR_RDATA;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
